// File: rtl/mem_access_unit_if.sv
// ============================================================================
// Module      : mem_access_unit_if
// Description : Pipeline-side request and memory-bus signal bundle for
//               mem_access_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_access_unit_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    // The access unit itself.
    modport slave (
        input  mem_read, mem_write, addr, wdata, bus_ack, bus_rdata,
        output rdata, stall, done, err, bus_req, bus_we, bus_addr, bus_wdata
    );

    // Pipeline control plus memory responder, as seen from outside the unit.
    modport master (
        output mem_read, mem_write, addr, wdata, bus_ack, bus_rdata,
        input  rdata, stall, done, err, bus_req, bus_we, bus_addr, bus_wdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module      : mem_access_unit
// Description : Single-outstanding LW/SW memory access FSM with bus timeout.
//               Optional macro MEM_ACCESS_ALIGN_CHECK_EN rejects misaligned
//               addresses instead of forcing word alignment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit #(
    parameter int unsigned TIMEOUT = 15
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mem_access_unit_if.slave  mif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter holds (REQ cycles elapsed - 1), so expiry is on the last allowed cycle.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [31:0] rdata_q;
    logic [31:0] bus_addr_q;
    logic [31:0] bus_wdata_q;
    logic        bus_we_q;
    logic        bus_req_q;
    logic        done_q;
    logic        err_q;

    logic [31:0] bus_addr_d;
    logic        addr_misaligned;

    assign bus_addr_d = {mif.addr[31:2], 2'b00};

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    assign addr_misaligned = (mif.addr[1:0] != 2'b00);
`else
    assign addr_misaligned = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            rdata_q     <= 32'd0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            bus_we_q    <= 1'b0;
            bus_req_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (mif.mem_read && mif.mem_write) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else if (mif.mem_read || mif.mem_write) begin
                        if (addr_misaligned) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            bus_addr_q  <= bus_addr_d;
                            bus_wdata_q <= mif.wdata;
                            bus_we_q    <= mif.mem_write;
                            bus_req_q   <= 1'b1;
                            cnt_q       <= 8'd0;
                            state_q     <= ST_REQ;
                        end
                    end
                end

                ST_REQ: begin
                    // Acknowledge takes priority over a coincident timeout.
                    if (mif.bus_ack) begin
                        if (!bus_we_q) begin
                            rdata_q <= mif.bus_rdata;
                        end
                        bus_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        err_q     <= 1'b0;
                        state_q   <= ST_DONE;
                    end else if (cnt_q == TMO_LAST) begin
                        bus_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        err_q     <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end

                ST_DONE: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    bus_req_q <= 1'b0;
                    done_q    <= 1'b0;
                    err_q     <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign mif.stall     = ((state_q == ST_IDLE) && (mif.mem_read || mif.mem_write))
                         || (state_q == ST_REQ);
    assign mif.rdata     = rdata_q;
    assign mif.done      = done_q;
    assign mif.err       = err_q;
    assign mif.bus_req   = bus_req_q;
    assign mif.bus_we    = bus_we_q;
    assign mif.bus_addr  = bus_addr_q;
    assign mif.bus_wdata = bus_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Scoreboard testbench for mem_access_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

    localparam int TMO = 15;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_access_unit_if mif ();

    mem_access_unit #(.TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .mif (mif)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          stall_n;
        int          req_n;
        logic        we;
        logic [31:0] baddr;
        logic [31:0] wdata;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          ack_at = 0;
    logic [31:0] rd_val = 32'd0;
    logic        stray_ack = 1'b0;
    logic [31:0] exp_rdata = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Memory responder: acks on the ack_at-th REQ cycle (0 = never).
    initial begin : responder
        int n;
        n = 0;
        mif.bus_ack   = 1'b0;
        mif.bus_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (mif.bus_req === 1'b1) n++;
            else n = 0;
            mif.bus_ack   = ((mif.bus_req === 1'b1) && (n == ack_at)) || stray_ack;
            mif.bus_rdata = rd_val;
        end
    end

    // Monitor: counts stall/bus_req cycles per access and scores each done pulse.
    initial begin : monitor
        int          sn;
        int          rn;
        logic        we_s;
        logic [31:0] a_s;
        logic [31:0] w_s;
        exp_t        e;
        sn = 0;
        rn = 0;
        we_s = 1'b0;
        a_s = 32'd0;
        w_s = 32'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sn = 0;
                rn = 0;
            end else begin
                if (mif.stall === 1'b1) sn++;
                if (mif.bus_req === 1'b1) begin
                    if (rn == 0) begin
                        we_s = mif.bus_we;
                        a_s  = mif.bus_addr;
                        w_s  = mif.bus_wdata;
                    end
                    rn++;
                end
                if (mif.done === 1'b1) begin
                    chk("done_stall_low", {31'd0, mif.stall}, 32'd0);
                    chk("done_busreq_low", {31'd0, mif.bus_req}, 32'd0);
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done actual=1 expected=0");
                    end else begin
                        e = sb.pop_front();
                        chk("err", {31'd0, mif.err}, {31'd0, e.err});
                        chk("rdata", mif.rdata, e.rdata);
                        chk("stall_cycles", sn, e.stall_n);
                        chk("req_cycles", rn, e.req_n);
                        if (e.req_n > 0) begin
                            chk("bus_we", {31'd0, we_s}, {31'd0, e.we});
                            chk("bus_addr", a_s, e.baddr);
                            chk("bus_wdata", w_s, e.wdata);
                        end
                    end
                    sn = 0;
                    rn = 0;
                end
            end
        end
    end

    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input int ack, input logic [31:0] rv,
                          input logic exp_err, input int exp_stall, input int exp_req,
                          input logic [31:0] exp_baddr);
        exp_t e;
        bit   seen;
        ack_at = ack;
        rd_val = rv;
        @(posedge clk);
        #1;
        mif.mem_read  = rd;
        mif.mem_write = wr;
        mif.addr      = a;
        mif.wdata     = wd;
        if (!exp_err && rd && !wr) exp_rdata = rv;
        e.err     = exp_err;
        e.rdata   = exp_rdata;
        e.stall_n = exp_stall;
        e.req_n   = exp_req;
        e.we      = wr;
        e.baddr   = exp_baddr;
        e.wdata   = wd;
        sb.push_back(e);
        @(posedge clk);
        #1;
        mif.mem_read  = 1'b0;
        mif.mem_write = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mif.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=0 expected=1 addr=%h", a);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_bus_req"}, {31'd0, mif.bus_req}, 32'd0);
        chk({tag, "_done"}, {31'd0, mif.done}, 32'd0);
        chk({tag, "_err"}, {31'd0, mif.err}, 32'd0);
        chk({tag, "_stall"}, {31'd0, mif.stall}, 32'd0);
        chk({tag, "_rdata"}, mif.rdata, 32'd0);
        chk({tag, "_bus_addr"}, mif.bus_addr, 32'd0);
        chk({tag, "_bus_we"}, {31'd0, mif.bus_we}, 32'd0);
        chk({tag, "_bus_wdata"}, mif.bus_wdata, 32'd0);
    endtask

    initial begin : stimulus
        mif.mem_read  = 1'b0;
        mif.mem_write = 1'b0;
        mif.addr      = 32'd0;
        mif.wdata     = 32'd0;
        rst = 1'b1;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // LW, ack on the third REQ cycle.
        access(1'b1, 1'b0, 32'h100, 32'h0, 3, 32'hCAFEF00D, 1'b0, 4, 3, 32'h100);
        // SW, ack on the first REQ cycle; rdata must keep the last load.
        access(1'b0, 1'b1, 32'h204, 32'h12345678, 1, 32'hDEADBEEF, 1'b0, 2, 1, 32'h204);

        // Stray acknowledge while idle must not disturb rdata.
        rd_val = 32'h55555555;
        @(posedge clk);
        #1;
        stray_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        stray_ack = 1'b0;
        chk("stray_ack_rdata", mif.rdata, 32'hCAFEF00D);
        chk("stray_ack_no_done", {31'd0, mif.done}, 32'd0);
        @(posedge clk);

        // Timeout: no ack, then ack landing on the final allowed cycle.
        access(1'b1, 1'b0, 32'h300, 32'h0, 0, 32'h11111111, 1'b1, TMO + 1, TMO, 32'h300);
        access(1'b1, 1'b0, 32'h304, 32'h0, TMO, 32'hA5A5A5A5, 1'b0, TMO + 1, TMO, 32'h304);

        // Conflicting read+write request.
        access(1'b1, 1'b1, 32'h400, 32'h9, 1, 32'h22222222, 1'b1, 1, 0, 32'h400);

        // Misaligned load.
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        access(1'b1, 1'b0, 32'h102, 32'h0, 1, 32'h0BADF00D, 1'b1, 1, 0, 32'h100);
`else
        access(1'b1, 1'b0, 32'h102, 32'h0, 1, 32'h0BADF00D, 1'b0, 2, 1, 32'h100);
`endif

        // Reset two cycles into REQ aborts silently.
        ack_at = 0;
        @(posedge clk);
        #1;
        mif.mem_read = 1'b1;
        mif.addr     = 32'h500;
        @(posedge clk);
        #1;
        mif.mem_read = 1'b0;
        chk("pre_reset_bus_req", {31'd0, mif.bus_req}, 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midreq_reset");
        exp_rdata = 32'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Back-to-back accesses after reset.
        access(1'b1, 1'b0, 32'h600, 32'h0, 1, 32'h13579BDF, 1'b0, 2, 1, 32'h600);
        access(1'b1, 1'b0, 32'h604, 32'h0, 2, 32'h2468ACE0, 1'b0, 3, 2, 32'h604);
        access(1'b0, 1'b1, 32'h608, 32'hFEEDFACE, 2, 32'h77777777, 1'b0, 3, 2, 32'h608);

        repeat (3) @(posedge clk);
        #1;
        chk("final_rdata", mif.rdata, 32'h2468ACE0);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: TIMEOUT, default 15, max REQ cycles waited for bus_ack before abort (1..255).
REQ-002 Ports, as name direction width meaning:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_read  in  1  load request from control decode (LW).
- mem_write  in  1  store request from control decode (SW).
- addr  in  32  byte address from ALU result.
- wdata  in  32  store data from register file rt.
- rdata  out  32  load data to write-back mux.
- stall  out  1  freeze PC/pipeline while access pending.
- done  out  1  one-cycle pulse, access finished.
- err  out  1  one-cycle pulse coincident with done, access failed.
- bus_req  out  1  memory bus request.
- bus_we  out  1  1 = write, 0 = read.
- bus_addr  out  32  bus byte address.
- bus_wdata  out  32  bus write data.
- bus_ack  in  1  memory responder acknowledge, single cycle.
- bus_rdata  in  32  read data, valid when bus_ack=1 and bus_we=0.

Function
REQ-003 FSM states IDLE, REQ, DONE; exactly one active.
REQ-004 IDLE: mem_read XOR mem_write high -> latch addr, wdata, we=mem_write into bus_addr/bus_wdata/bus_we, clear timeout counter, go REQ.
REQ-005 IDLE with mem_read and mem_write both high: no bus cycle; go DONE with err.
REQ-006 stall = 1 combinationally when (IDLE and (mem_read or mem_write)) or state==REQ; 0 in DONE and in idle-without-request.
REQ-007 REQ: bus_req=1; bus_we, bus_addr, bus_wdata held stable until exit; counter increments each REQ cycle.
REQ-008 REQ with bus_ack=1: reads capture bus_rdata into rdata; go DONE, err=0. Minimum latency request-to-done = 2 cycles (ack in first REQ cycle).
REQ-009 REQ with counter reaching TIMEOUT and no ack: drop bus_req, go DONE with err=1, rdata unchanged.
REQ-010 bus_ack in the same cycle as timeout expiry: ack wins, no err.
REQ-011 DONE: lasts exactly one cycle, done=1, err per cause, bus_req=0, stall=0; mem_read/mem_write ignored; next state IDLE.
REQ-012 bus_ack outside REQ ignored; no state or rdata change.
REQ-013 rdata holds last successful load value; writes and failed accesses do not modify it.
REQ-014 bus_req deasserts the cycle after ack; never asserted in IDLE or DONE.

Reset
REQ-015 rst=1 forces, asynchronously: state IDLE, counter 0, rdata 0, bus_addr 0, bus_wdata 0, bus_we 0, bus_req 0, done 0, err 0.
REQ-016 rst asserted mid-REQ aborts the access with no done/err pulse; bus_req drops immediately.
REQ-017 After rst deasserts, first request accepted on next rising edge.

Configuration
REQ-018 Macro MEM_ACCESS_ALIGN_CHECK_EN defined: request in IDLE with addr[1:0]!=0 issues no bus cycle, goes DONE with err=1.
REQ-019 Macro not defined: no alignment check; bus_addr[1:0] driven 0 (word-aligned access).

Verification
REQ-020 LW addr=0x100, ack 3 cycles after bus_req, bus_rdata=0xCAFEF00D -> stall 4 cycles, done pulse, rdata=0xCAFEF00D, err=0.
REQ-021 SW addr=0x204, wdata=0x12345678, ack in first REQ cycle -> bus_we=1, bus_addr=0x204, bus_wdata=0x12345678, stall 2 cycles, done, rdata unchanged.
REQ-022 LW, TIMEOUT=15, no ack -> bus_req high 15 cycles, then done+err, rdata unchanged; ack on cycle 15 -> done, no err.
REQ-023 mem_read=mem_write=1 -> no bus_req, done+err next cycle; addr=0x102 -> with MEM_ACCESS_ALIGN_CHECK_EN err, without it bus_addr=0x100 and normal access.
REQ-024 rst pulsed 2 cycles into REQ -> all outputs 0 immediately, no done; back-to-back LW after reset completes normally.
